mem_responder: RTL and testbench

Responder end of the cache-to-main-memory request bundle: a 32 × 8 main-memory model that accepts one read or write request at a time and answers after a programmable number of wait states. It sits between the cache controller's memory-request port and the board I/O, replacing the zero-wait-state RAM macro. The cache miss and write-back paths can then be exercised against a slow memory, with an explicit handshake instead of fixed one-cycle timing.

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/mem_array.sv | 54 +++++
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants, state codes and helpers for the
//               main-memory responder and the cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Default geometry shared with the cache controller
  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 8;

  // Legal wait-state range and the counter width that covers it
  localparam int LATENCY_MIN = 0;
  localparam int LATENCY_MAX = 7;
  localparam int CNT_W       = 3;

  // FSM state codes; fixed values because they drive the 7-segment display
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    MS_IDLE = 3'd0,
    MS_WAIT = 3'd1,
    MS_RESP = 3'd2
  } mem_state_e;

  localparam logic [STATE_W-1:0] ST_IDLE = MS_IDLE;
  localparam logic [STATE_W-1:0] ST_WAIT = MS_WAIT;
  localparam logic [STATE_W-1:0] ST_RESP = MS_RESP;

  // Saturate a requested latency into the supported range
  function automatic logic [CNT_W-1:0] clamp_latency(input int lat);
    int l;
    l = lat;
    if (l < LATENCY_MIN) l = LATENCY_MIN;
    if (l > LATENCY_MAX) l = LATENCY_MAX;
    return CNT_W'(l);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : 2^ADDR_W x DATA_W register storage. Resets to the identity
//               pattern (word i holds i), synchronous write, combinational
//               read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // One register per word so each can carry its own identity reset value
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(i);
      logic [DATA_W-1:0] word_d;

      // Next value: new data when this word is the write target
      always_comb begin
        word_d = mem_q[i];
        if (we && (waddr == ADDR_W'(i))) word_d = wdata;
      end

      // Word storage, identity pattern on reset
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) mem_q[i] <= RST_VAL;
        else         mem_q[i] <= word_d;
      end
    end
  endgenerate

  // Asynchronous read port
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Responder side of the cache memory-request bundle. Accepts
//               one read/write at a time, waits LATENCY cycles, performs the
//               access and pulses resp_valid for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wren,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_data,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_data,
  output logic               busy,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] LAT_CNT = clamp_latency(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               wren_q, wren_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;

  // Access strobe and operands; sourced from the live inputs when LATENCY=0
  // (access on the accept edge) and from the capture registers otherwise.
  logic               acc_en;
  logic               acc_wren;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_data;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_rdata;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clock  (clock),
    .resetn (resetn),
    .we     (mem_we),
    .waddr  (acc_addr),
    .wdata  (acc_data),
    .raddr  (acc_addr),
    .rdata  (mem_rdata)
  );

  // FSM next-state, wait counter, request capture and access selection
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    wren_d      = wren_q;
    addr_d      = addr_q;
    data_d      = data_q;
    acc_en      = 1'b0;
    acc_wren    = wren_q;
    acc_addr    = addr_q;
    acc_data    = data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wren_d     = req_wren;
          addr_d     = req_addr;
          data_d     = req_data;
          wait_cnt_d = LAT_CNT;
          if (LAT_CNT == '0) begin
            acc_en   = 1'b1;
            acc_wren = req_wren;
            acc_addr = req_addr;
            acc_data = req_data;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - CNT_ONE;
        // A zero count cannot occur here; treating it like 1 avoids underflow
        if (wait_cnt_q <= CNT_ONE) begin
          wait_cnt_d = '0;
          acc_en     = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase

    mem_we      = acc_en & acc_wren;
    resp_data_d = resp_data_q;
    if (acc_en) resp_data_d = acc_wren ? acc_data : mem_rdata;
  end

  // State, counter and capture registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
    state      = state_q;
    resp_data  = resp_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Instance A uses
//               LATENCY=3, instance B uses LATENCY=0. Directed vectors,
//               multi-cycle corner cases and random traffic checked against
//               an array memory model and the LATENCY+1 response rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int LAT_A = 3;
  localparam int LAT_B = 0;

  logic clock;
  logic resetn;

  logic       rv0, ry0, rw0, rsv0, bz0;
  logic [4:0] ra0;
  logic [7:0] rwd0, rd0;
  logic [2:0] st0;
  logic       rv1, ry1, rw1, rsv1, bz1;
  logic [4:0] ra1;
  logic [7:0] rwd1, rd1;
  logic [2:0] st1;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] model [2][32];

  mem_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(LAT_A)) dut_a (
    .clock(clock), .resetn(resetn),
    .req_valid(rv0), .req_ready(ry0), .req_wren(rw0), .req_addr(ra0),
    .req_data(rwd0), .resp_valid(rsv0), .resp_data(rd0), .busy(bz0),
    .state(st0)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(LAT_B)) dut_b (
    .clock(clock), .resetn(resetn),
    .req_valid(rv1), .req_ready(ry1), .req_wren(rw1), .req_addr(ra1),
    .req_data(rwd1), .resp_valid(rsv1), .resp_data(rd1), .busy(bz1),
    .state(st1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         wr;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int lat_of(input int d);
    return (d != 0) ? LAT_B : LAT_A;
  endfunction

  function automatic logic g_ry(input int d);  return (d != 0) ? ry1  : ry0;  endfunction
  function automatic logic g_rsv(input int d); return (d != 0) ? rsv1 : rsv0; endfunction
  function automatic logic g_bz(input int d);  return (d != 0) ? bz1  : bz0;  endfunction
  function automatic logic [7:0] g_rd(input int d); return (d != 0) ? rd1 : rd0; endfunction
  function automatic logic [2:0] g_st(input int d); return (d != 0) ? st1 : st0; endfunction

  task automatic set_req(input int d, input logic v, input logic w,
                         input logic [4:0] a, input logic [7:0] dat);
    if (d != 0) begin rv1 = v; rw1 = w; ra1 = a; rwd1 = dat; end
    else        begin rv0 = v; rw0 = w; ra0 = a; rwd0 = dat; end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) model[d][i] = 8'(i);
  endtask

  task automatic chk_reset_state(input int d, input string nm);
    chk({nm, "_ready"}, g_ry(d), 1);
    chk({nm, "_rvalid"}, g_rsv(d), 0);
    chk({nm, "_rdata"}, g_rd(d), 0);
    chk({nm, "_busy"}, g_bz(d), 0);
    chk({nm, "_state"}, g_st(d), 0);
  endtask

  // One full transaction: present, wait for acceptance, scramble the inputs,
  // then expect exactly one response LATENCY+1 cycles after acceptance.
  task automatic xact(input int d, input bit wr, input logic [4:0] a,
                      input logic [7:0] wd, input logic [7:0] exp, input string nm);
    int n;
    int k;
    bit found;
    bit wait_ok;
    logic [7:0] got;
    logic [2:0] gst;
    @(negedge clock);
    set_req(d, 1'b1, wr, a, wd);
    n = 0;
    while (!g_ry(d) && n < 20) begin @(negedge clock); n++; end
    chk({nm, "_accept"}, g_ry(d), 1);
    @(posedge clock); #1;
    set_req(d, 1'b0, 1'($urandom), 5'($urandom), 8'($urandom));
    k = 0; found = 0; wait_ok = 1; got = 'x; gst = 'x;
    while (!found && k < LAT_A + 8) begin
      @(negedge clock);
      k++;
      if (g_rsv(d)) begin
        found = 1; got = g_rd(d); gst = g_st(d);
      end else if (g_ry(d) || !g_bz(d)) begin
        wait_ok = 0;
      end
    end
    chk({nm, "_resp_seen"}, found, 1);
    chk({nm, "_latency"}, k, lat_of(d) + 1);
    chk({nm, "_data"}, got, exp);
    chk({nm, "_resp_state"}, gst, 2);
    chk({nm, "_busy_wait"}, wait_ok, 1);
    @(negedge clock);
    chk({nm, "_after"}, {g_rsv(d), g_ry(d), g_st(d)}, {1'b0, 1'b1, 3'd0});
  endtask

  initial begin : main
    vec_t vecs[8];
    int   acc[2];
    int   nacc;
    int   npulse;
    logic [7:0] pd[2];
    bit   accepted;
    bit   wr;
    logic [4:0] a;
    logic [7:0] wd;
    logic [7:0] exp;
    int   d;

    vecs[0] = '{wr: 1'b0, a: 5'h05, d: 8'h00, exp: 8'h05};
    vecs[1] = '{wr: 1'b1, a: 5'h1F, d: 8'hA5, exp: 8'hA5};
    vecs[2] = '{wr: 1'b0, a: 5'h1F, d: 8'h00, exp: 8'hA5};
    vecs[3] = '{wr: 1'b0, a: 5'h1E, d: 8'h00, exp: 8'h1E};
    vecs[4] = '{wr: 1'b1, a: 5'h00, d: 8'h3C, exp: 8'h3C};
    vecs[5] = '{wr: 1'b0, a: 5'h00, d: 8'h00, exp: 8'h3C};
    vecs[6] = '{wr: 1'b1, a: 5'h1F, d: 8'h5A, exp: 8'h5A};
    vecs[7] = '{wr: 1'b0, a: 5'h1F, d: 8'h00, exp: 8'h5A};

    resetn = 1'b0;
    set_req(0, 1'b0, 1'b0, 5'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 5'h0, 8'h0);
    model_reset();
    repeat (3) @(negedge clock);
    chk_reset_state(0, "rst_a");
    chk_reset_state(1, "rst_b");
    resetn = 1'b1;
    @(negedge clock);
    chk_reset_state(0, "post_rst_a");

    // Directed vectors on the LATENCY=3 instance
    for (int i = 0; i < 8; i++) begin
      xact(0, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));
      if (vecs[i].wr) model[0][vecs[i].a] = vecs[i].d;
    end

    // LATENCY=0: response in the cycle right after acceptance, IDLE->RESP->IDLE
    xact(1, 1'b0, 5'h10, 8'h00, 8'h10, "l0_read");

    // Back-to-back reads with req_valid held continuously
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 5'h02, 8'h00);
    nacc = 0; npulse = 0; pd[0] = 'x; pd[1] = 'x; acc[0] = -1; acc[1] = -1;
    for (int c = 0; c < 20; c++) begin
      accepted = 0;
      if (rsv0) begin
        if (npulse < 2) pd[npulse] = rd0;
        npulse++;
      end
      if (rv0 && ry0) begin
        if (nacc < 2) acc[nacc] = c;
        nacc++;
        accepted = 1;
      end
      @(posedge clock); #1;
      if (accepted) begin
        if (nacc == 1) ra0 = 5'h03;
        else rv0 = 1'b0;
      end
      @(negedge clock);
    end
    chk("b2b_accepts", nacc, 2);
    chk("b2b_gap", acc[1] - acc[0], LAT_A + 2);
    chk("b2b_pulses", npulse, 2);
    chk("b2b_data0", pd[0], 8'h02);
    chk("b2b_data1", pd[1], 8'h03);

    // Request presented during WAIT must be ignored entirely
    set_req(0, 1'b1, 1'b0, 5'h09, 8'h00);
    while (!ry0) @(negedge clock);
    @(posedge clock); #1;
    rv0 = 1'b0;
    @(negedge clock);
    set_req(0, 1'b1, 1'b1, 5'h07, 8'hEE);
    @(posedge clock); #1;
    rv0 = 1'b0;
    npulse = 0; pd[0] = 'x;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (rsv0) begin
        if (npulse == 0) pd[0] = rd0;
        npulse++;
      end
    end
    chk("busy_ign_pulses", npulse, 1);
    chk("busy_ign_data", pd[0], 8'h09);
    xact(0, 1'b0, 5'h07, 8'h00, model[0][7], "busy_ign_nowrite");

    // Reset during WAIT of a write: no response, no write, identity restored
    @(negedge clock);
    set_req(0, 1'b1, 1'b1, 5'h04, 8'hFF);
    while (!ry0) @(negedge clock);
    @(posedge clock); #1;
    rv0 = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    #2;
    chk_reset_state(0, "midrst");
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    npulse = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (rsv0) npulse++;
    end
    chk("midrst_no_resp", npulse, 0);
    xact(0, 1'b0, 5'h04, 8'h00, 8'h04, "midrst_read04");
    xact(0, 1'b0, 5'h1F, 8'h00, 8'h1F, "midrst_read1f");

    // Random traffic on both instances against the array model
    for (int i = 0; i < 60; i++) begin
      d   = i % 2;
      wr  = 1'($urandom_range(0, 1));
      a   = 5'($urandom);
      wd  = 8'($urandom);
      exp = wr ? wd : model[d][a];
      xact(d, wr, a, wd, exp, $sformatf("rnd%0d", i));
      if (wr) model[d][a] = wd;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
